// File: rtl/regfile_scoreboard.sv
// Hazard scoreboard beside decode: tracks registers with writes in flight and
// holds off decode on RAW/WAW hazards or when too many writes are outstanding.
module regfile_scoreboard #(
   parameter int MAX_OUT = 4,
   parameter int CW      = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          id_valid,
   input  logic [4:0]    id_rs,
   input  logic [4:0]    id_rt,
   input  logic          id_uses_rs,
   input  logic          id_uses_rt,
   input  logic          id_wr_en,
   input  logic [4:0]    id_dst,
   output logic          id_ready,
   input  logic          wb_valid,
   input  logic [4:0]    wb_dst,
   input  logic          flush,
   output logic [31:0]   pending,
   output logic [CW-1:0] outstanding,
   output logic [31:0]   stall_cycles,
   output logic          wb_err
);

   logic        rs_busy;
   logic        rt_busy;
   logic        dst_busy;
   logic        wb_free;
   logic        full;
   logic        issue;
   logic [31:0] pending_next;

   // A register written back this cycle is already readable (bypass), so it
   // never counts as busy even though its pending bit is still set.
   assign rs_busy  = (id_rs != 5'd0) && pending[id_rs] && !(wb_valid && wb_dst == id_rs);
   assign rt_busy  = (id_rt != 5'd0) && pending[id_rt] && !(wb_valid && wb_dst == id_rt);
   assign dst_busy = (id_dst != 5'd0) && pending[id_dst] && !(wb_valid && wb_dst == id_dst);

   assign wb_free  = wb_valid && (wb_dst != 5'd0) && pending[wb_dst];
   assign full     = (outstanding == CW'(MAX_OUT)) && !wb_free;

   assign id_ready = !flush
                     && !(id_uses_rs && rs_busy)
                     && !(id_uses_rt && rt_busy)
                     && !(id_wr_en && dst_busy)
                     && !(id_wr_en && (id_dst != 5'd0) && full);

   assign issue = id_valid && id_ready && id_wr_en && (id_dst != 5'd0);

   // Free before set so a register retired and reissued in one cycle stays busy.
   always_comb begin
      pending_next = pending;
      if (wb_free)
         pending_next[wb_dst] = 1'b0;
      if (issue)
         pending_next[id_dst] = 1'b1;
      pending_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending      <= '0;
         outstanding  <= '0;
         stall_cycles <= '0;
         wb_err       <= 1'b0;
      end else begin
         if (id_valid && !id_ready && (stall_cycles != 32'hFFFF_FFFF))
            stall_cycles <= stall_cycles + 32'd1;
         if (flush) begin
            pending     <= '0;
            outstanding <= '0;
         end else begin
            pending <= pending_next;
            if (issue && !wb_free)
               outstanding <= outstanding + CW'(1);
            else if (!issue && wb_free)
               outstanding <= outstanding - CW'(1);
            if (wb_valid && !wb_free)
               wb_err <= 1'b1;
         end
      end
   end

endmodule
